// File: rtl/sobol_seq_ctrl_if.sv
// Sample stream between the Sobol sequencer and its consumer.
// A sample moves on a rising edge where out_valid && out_ready; while out_valid is
// high and out_ready is low, the producer holds out_data and out_valid unchanged.
interface sobol_seq_ctrl_if #(
    parameter int W = 32
);
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/sobol_seq_ctrl.sv
// One-dimension Sobol sequencer: Gray-code recurrence x(n+1) = x(n) ^ v[c(n)],
// with a direction-vector table writable while idle and a valid/ready sample stream.
module sobol_seq_ctrl #(
    parameter int W     = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_points,
    input  logic             dv_we,
    input  logic [AW-1:0]    dv_addr,
    input  logic [W-1:0]     dv_data,
    sobol_seq_ctrl_if.master out_if,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OUT  = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Wide enough to hold any bit position of idx, including positions >= W.
    localparam int CW = $clog2(CNT_W) + 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] last_idx;
    logic [W-1:0]     x;
    logic [W-1:0]     data_q;
    logic             valid_q;
    logic [W-1:0]     v_tab [W];

    logic [CW-1:0]    zero_pos;
    logic [W-1:0]     xor_term;
    logic [W-1:0]     x_next;
    logic             xfer;

    assign xfer      = valid_q & out_if.out_ready;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;

    // Scan from the top so the lowest clear bit is the last assignment to win.
    always_comb begin
        zero_pos = '0;
        for (int i = CNT_W - 1; i >= 0; i--) begin
            if (!idx[i]) begin
                zero_pos = CW'(i);
            end
        end
    end

    always_comb begin
        xor_term = '0;
        if (int'(zero_pos) < W) begin
            xor_term = v_tab[zero_pos[AW-1:0]];
        end
    end

    assign x_next = x ^ xor_term;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < W; k++) begin
                v_tab[k] <= '0;
            end
        end else if (state == S_IDLE && dv_we) begin
            v_tab[dv_addr] <= dv_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            last_idx <= '0;
            x        <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_points == '0) begin
                            state <= S_DONE;
                        end else begin
                            state    <= S_OUT;
                            last_idx <= num_points - CNT_W'(1);
                            idx      <= '0;
                            x        <= '0;
                            data_q   <= '0;
                            valid_q  <= 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (xfer) begin
                        valid_q <= 1'b0;
                        state   <= (idx == last_idx) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    x       <= x_next;
                    idx     <= idx + CNT_W'(1);
                    data_q  <= x_next;
                    valid_q <= 1'b1;
                    state   <= S_OUT;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobol_seq_ctrl.sv
// Self-checking bench for sobol_seq_ctrl: a Gray-code reference model fills an
// expected queue, a negedge monitor compares every transfer, and directed scenarios pin literals.
module tb_sobol_seq_ctrl;
    localparam int W     = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_points = '0;
    logic             dv_we = 1'b0;
    logic [AW-1:0]    dv_addr = '0;
    logic [W-1:0]     dv_data = '0;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    sobol_seq_ctrl_if #(.W(W)) s_if ();

    sobol_seq_ctrl #(.W(W), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_points (num_points),
        .dv_we      (dv_we),
        .dv_addr    (dv_addr),
        .dv_data    (dv_data),
        .out_if     (s_if),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int           checks = 0;
    int           failures = 0;
    int           done_cnt = 0;
    int           busy_cnt = 0;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] got_q [$];
    logic [W-1:0] model_v [W];
    bit           held_valid = 1'b0;
    logic [W-1:0] held_data = '0;
    logic [W-1:0] lit_s1 [5];
    logic [W-1:0] lit_s6 [5];
    logic [W-1:0] lit_zero [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // x(n) is the XOR of v[k] over the set bits of gray(n) = n ^ (n >> 1).
    function automatic logic [W-1:0] model_sample(input int n);
        logic [CNT_W-1:0] g;
        logic [W-1:0]     acc;
        g   = CNT_W'(n) ^ (CNT_W'(n) >> 1);
        acc = '0;
        for (int k = 0; k < W; k++) begin
            if (g[k]) acc = acc ^ model_v[k];
        end
        return acc;
    endfunction

    // ---------------- monitor / compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                check("hold_valid", 64'(s_if.out_valid), 64'(1));
                check("hold_data", 64'(s_if.out_data), 64'(held_data));
            end
            if (s_if.out_valid) begin
                if (s_if.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_sample", 64'(s_if.out_data), 64'hDEAD_0000_0000_0000);
                    end else begin
                        check("sample", 64'(s_if.out_data), 64'(exp_q.pop_front()));
                    end
                    got_q.push_back(s_if.out_data);
                    held_valid = 1'b0;
                end else begin
                    held_valid = 1'b1;
                    held_data  = s_if.out_data;
                end
            end else begin
                held_valid = 1'b0;
            end
            if (done) begin
                done_cnt++;
                check("done_after_samples", 64'(exp_q.size()), 64'(0));
            end
            if (busy) busy_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_dv(input logic [AW-1:0] addr, input logic [W-1:0] data, input bit upd);
        dv_we   = 1'b1;
        dv_addr = addr;
        dv_data = data;
        if (upd) model_v[addr] = data;
        tick();
        dv_we = 1'b0;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < W; k++) write_dv(AW'(k), W'(32'h8000_0000 >> k), 1'b1);
    endtask

    task automatic kick(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(model_sample(i));
        start      = 1'b1;
        num_points = CNT_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'(1));
        tick();
    endtask

    task automatic wait_got(input int n, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (got_q.size() >= n) seen = 1'b1;
        end
        check("got_timeout", 64'(seen), 64'(1));
    endtask

    task automatic check_got(input string name, input int n, input logic [W-1:0] e [5]);
        check({name, "_len"}, 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) check(name, 64'(got_q[i]), 64'(e[i]));
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int d0;
        int b0;
        lit_s1   = '{32'h0000_0000, 32'h8000_0000, 32'hC000_0000, 32'h4000_0000, 32'h6000_0000};
        lit_s6   = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h0};
        lit_zero = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int k = 0; k < W; k++) model_v[k] = '0;
        s_if.out_ready = 1'b1;

        repeat (3) tick();
        check("rst_valid", 64'(s_if.out_valid), 64'(0));
        check("rst_data", 64'(s_if.out_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(0));
        rst = 1'b1;
        tick();

        // 1: ramp table, five samples at full rate
        load_ramp();
        got_q.delete(); d0 = done_cnt; b0 = busy_cnt;
        kick(5);
        check("s1_first_valid", 64'(s_if.out_valid), 64'(1));
        check("s1_first_data", 64'(s_if.out_data), 64'(0));
        wait_done(100);
        check_got("s1_seq", 5, lit_s1);
        check("s1_done_count", 64'(done_cnt - d0), 64'(1));
        check("s1_busy_cycles", 64'(busy_cnt - b0), 64'(10));
        check("s1_busy_low", 64'(busy), 64'(0));

        // 2: stall the consumer on sample 2
        got_q.delete(); d0 = done_cnt;
        kick(5);
        wait_got(2, 50);
        s_if.out_ready = 1'b0;
        repeat (4) tick();
        check("s2_stall_valid", 64'(s_if.out_valid), 64'(1));
        check("s2_stall_data", 64'(s_if.out_data), 64'h0000_0000_C000_0000);
        s_if.out_ready = 1'b1;
        wait_done(100);
        check_got("s2_seq", 5, lit_s1);
        check("s2_done_count", 64'(done_cnt - d0), 64'(1));

        // 3: empty run
        got_q.delete(); d0 = done_cnt; b0 = busy_cnt;
        kick(0);
        check("s3_done_now", 64'(done), 64'(1));
        check("s3_busy_now", 64'(busy), 64'(1));
        check("s3_no_valid", 64'(s_if.out_valid), 64'(0));
        tick();
        check("s3_done_gone", 64'(done), 64'(0));
        check("s3_busy_gone", 64'(busy), 64'(0));
        check("s3_done_count", 64'(done_cnt - d0), 64'(1));
        check("s3_busy_cycles", 64'(busy_cnt - b0), 64'(1));
        check("s3_no_samples", 64'(got_q.size()), 64'(0));

        // 4: table write and restart attempts during a run are ignored
        got_q.delete(); d0 = done_cnt;
        kick(5);
        tick();
        dv_we = 1'b1; dv_addr = '0; dv_data = 32'hFFFF_FFFF;
        start = 1'b1; num_points = CNT_W'(2);
        tick();
        dv_we = 1'b0; start = 1'b0;
        wait_done(100);
        check_got("s4_seq", 5, lit_s1);
        check("s4_done_count", 64'(done_cnt - d0), 64'(1));

        // 5: asynchronous reset while in CALC
        got_q.delete(); d0 = done_cnt;
        kick(5);
        wait_got(2, 50);
        check("s5_in_calc", 64'(dbg_state), 64'(2));
        rst = 1'b0;
        #1;
        check("s5_rst_valid", 64'(s_if.out_valid), 64'(0));
        check("s5_rst_data", 64'(s_if.out_data), 64'(0));
        check("s5_rst_busy", 64'(busy), 64'(0));
        check("s5_rst_done", 64'(done), 64'(0));
        for (int k = 0; k < W; k++) model_v[k] = '0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("s5_no_done", 64'(done_cnt - d0), 64'(0));
        got_q.delete();
        kick(3);
        wait_done(100);
        check_got("s5_cleared_tab", 3, lit_zero);
        load_ramp();
        got_q.delete();
        kick(5);
        wait_done(100);
        check_got("s5_reload_seq", 5, lit_s1);

        // 6: small vectors, with v[0] written in the same cycle as start
        write_dv(AW'(1), 32'h3, 1'b1);
        write_dv(AW'(2), 32'h5, 1'b1);
        got_q.delete(); d0 = done_cnt; b0 = busy_cnt;
        dv_we = 1'b1; dv_addr = '0; dv_data = 32'h1;
        model_v[0] = 32'h1;
        kick(4);
        dv_we = 1'b0;
        wait_done(100);
        check_got("s6_seq", 4, lit_s6);
        check("s6_done_count", 64'(done_cnt - d0), 64'(1));
        check("s6_busy_cycles", 64'(busy_cnt - b0), 64'(8));

        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
